// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UDM UART transmitter.
package uart_pkg;

  localparam int DEF_BITPERIOD_W = 29;
  localparam int UART_DATA_W     = 8;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = TX_IDLE,
    ST_START = TX_START,
    ST_DATA  = TX_DATA,
    ST_STOP  = TX_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_bitclk.sv
// Bit-period down-counter: reloads on restart or at each bit boundary and
// strobes bit_end for one cycle when the current bit has lasted its full period.
module uart_tx_bitclk #(
  parameter int W = 29
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en,
  input  logic         restart,
  input  logic [W-1:0] period,
  output logic         bit_end
);

  logic [W-1:0] cnt_r;
  logic [W-1:0] reload_s;

  // A zero period is treated as one clock per bit.
  assign reload_s = (period == {W{1'b0}}) ? {W{1'b0}} : period - {{(W-1){1'b0}}, 1'b1};
  assign bit_end  = en && (cnt_r == {W{1'b0}});

  // Count down within a bit; reload from the period at launch and at bit ends.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_r <= {W{1'b0}};
    end else if (restart) begin
      cnt_r <= reload_s;
    end else if (!en) begin
      cnt_r <= {W{1'b0}};
    end else if (cnt_r == {W{1'b0}}) begin
      cnt_r <= reload_s;
    end else begin
      cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-entry holding buffer, timed by the receiver's
// measured bit period. Define UART_TX_TWO_STOP_EN for two stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int   BITPERIOD_W = DEF_BITPERIOD_W,
  parameter logic IDLE_LEVEL  = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   locked_i,
  input  logic [BITPERIOD_W-1:0] bitperiod_i,
  input  logic                   tx_req_i,
  input  logic [UART_DATA_W-1:0] din_bi,
  output logic                   tx_rdy_o,
  output logic                   tx_o,
  output logic                   busy_o,
  output logic                   tx_done_tick_o
);

`ifdef UART_TX_TWO_STOP_EN
  localparam logic [2:0] STOP_LAST = 3'd1;
`else
  localparam logic [2:0] STOP_LAST = 3'd0;
`endif

  tx_state_e              state_r, state_n;
  logic [UART_DATA_W-1:0] shift_r, shift_n;
  logic [UART_DATA_W-1:0] buf_r, buf_n;
  logic                   buf_valid_r, buf_valid_n;
  logic [2:0]             bit_cnt_r, bit_cnt_n;
  logic [BITPERIOD_W-1:0] bp_q_r, bp_q_n;
  logic                   tx_r, tx_n;
  logic                   rdy_r, busy_r, done_r, done_n;
  logic                   launch_s, bit_end_s;
  logic [BITPERIOD_W-1:0] bp_sel_s;

  assign bp_sel_s = launch_s ? bitperiod_i : bp_q_r;

  uart_tx_bitclk #(.W(BITPERIOD_W)) u_bitclk (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en      (state_r != ST_IDLE),
    .restart (launch_s),
    .period  (bp_sel_s),
    .bit_end (bit_end_s)
  );

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r     <= ST_IDLE;
      shift_r     <= {UART_DATA_W{1'b0}};
      buf_r       <= {UART_DATA_W{1'b0}};
      buf_valid_r <= 1'b0;
      bit_cnt_r   <= 3'd0;
      bp_q_r      <= {BITPERIOD_W{1'b0}};
      tx_r        <= IDLE_LEVEL;
      rdy_r       <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_n;
      shift_r     <= shift_n;
      buf_r       <= buf_n;
      buf_valid_r <= buf_valid_n;
      bit_cnt_r   <= bit_cnt_n;
      bp_q_r      <= bp_q_n;
      tx_r        <= tx_n;
      rdy_r       <= !buf_valid_n;
      busy_r      <= (state_n != ST_IDLE) || buf_valid_n;
      done_r      <= done_n;
    end
  end

  // Next-state logic; launch covers both IDLE->START and back-to-back STOP->START.
  always_comb begin
    state_n     = state_r;
    shift_n     = shift_r;
    buf_n       = buf_r;
    buf_valid_n = buf_valid_r;
    bit_cnt_n   = bit_cnt_r;
    bp_q_n      = bp_q_r;
    tx_n        = tx_r;
    done_n      = 1'b0;
    launch_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        tx_n = IDLE_LEVEL;
        if (buf_valid_r && locked_i) begin
          launch_s = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          tx_n      = shift_r[0];
          bit_cnt_n = 3'd0;
          state_n   = ST_DATA;
        end else begin
          tx_n = 1'b0;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          if (bit_cnt_r == 3'd7) begin
            tx_n      = IDLE_LEVEL;
            bit_cnt_n = 3'd0;
            state_n   = ST_STOP;
          end else begin
            shift_n   = shift_r >> 1;
            tx_n      = shift_r[1];
            bit_cnt_n = bit_cnt_r + 3'd1;
          end
        end else begin
          state_n = ST_DATA;
        end
      end
      ST_STOP: begin
        tx_n = IDLE_LEVEL;
        if (bit_end_s) begin
          if (bit_cnt_r == STOP_LAST) begin
            done_n = 1'b1;
            if (buf_valid_r && locked_i) begin
              launch_s = 1'b1;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            bit_cnt_n = bit_cnt_r + 3'd1;
          end
        end else begin
          state_n = ST_STOP;
        end
      end
      default: begin
        state_n = ST_IDLE;
        tx_n    = IDLE_LEVEL;
      end
    endcase

    if (launch_s) begin
      shift_n     = buf_r;
      buf_valid_n = 1'b0;
      bp_q_n      = bitperiod_i;
      bit_cnt_n   = 3'd0;
      tx_n        = 1'b0;
      state_n     = ST_START;
    end else begin
      bp_q_n = bp_q_r;
    end

    // Accept only while empty, so it can never coincide with a launch.
    if (tx_req_i && rdy_r) begin
      buf_n       = din_bi;
      buf_valid_n = 1'b1;
    end else begin
      buf_n = buf_r;
    end
  end

  assign tx_o           = tx_r;
  assign tx_rdy_o       = rdy_r;
  assign busy_o         = busy_r;
  assign tx_done_tick_o = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx; honours UART_TX_TWO_STOP_EN.
module tb_uart_tx;

`ifdef UART_TX_TWO_STOP_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        locked_i = 1'b1;
  logic [28:0] bitperiod_i = 29'd16;
  logic        tx_req_i = 1'b0;
  logic [7:0]  din_bi = 8'h00;
  logic        tx_rdy_o, tx_o, busy_o, tx_done_tick_o;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  uart_tx dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .locked_i       (locked_i),
    .bitperiod_i    (bitperiod_i),
    .tx_req_i       (tx_req_i),
    .din_bi         (din_bi),
    .tx_rdy_o       (tx_rdy_o),
    .tx_o           (tx_o),
    .busy_o         (busy_o),
    .tx_done_tick_o (tx_done_tick_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] d);
    int t;
    t = 0;
    while (tx_rdy_o !== 1'b1 && t < 1000) begin
      @(negedge clk_i);
      t++;
    end
    check("rdy_before_send", tx_rdy_o, 1'b1);
    din_bi   = d;
    tx_req_i = 1'b1;
    @(negedge clk_i);
    tx_req_i = 1'b0;
  endtask

  // Waits (bounded) for the start bit, then checks every cycle of the frame
  // and the done tick; returns at the negedge where the tick is visible.
  task automatic watch_frame(input logic [7:0] d, input int bp, output int wait_cyc);
    int   idx;
    logic exp_bit;
    wait_cyc = 0;
    while (tx_o !== 1'b0 && wait_cyc < 400) begin
      @(negedge clk_i);
      wait_cyc++;
    end
    check("start_bit_seen", tx_o, 1'b0);
    for (int k = 0; k < FRAME_BITS * bp; k++) begin
      idx = k / bp;
      if (idx == 0)      exp_bit = 1'b0;
      else if (idx <= 8) exp_bit = d[idx-1];
      else               exp_bit = 1'b1;
      check($sformatf("tx_bit%0d_k%0d", idx, k), tx_o, exp_bit);
      if (k > 0) check("no_early_done", tx_done_tick_o, 1'b0);
      @(negedge clk_i);
    end
    check("done_tick", tx_done_tick_o, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, w2;

    // Reset state.
    repeat (3) @(negedge clk_i);
    check("rst_tx", tx_o, 1'b1);
    check("rst_rdy", tx_rdy_o, 1'b1);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", tx_done_tick_o, 1'b0);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // Single frame 0xA5 at 16 clocks/bit, with launch latency.
    send(8'hA5);
    check("lat_tx_before", tx_o, 1'b1);
    check("lat_rdy_low", tx_rdy_o, 1'b0);
    check("lat_busy", busy_o, 1'b1);
    @(negedge clk_i);
    check("lat_tx_fall", tx_o, 1'b0);
    check("lat_rdy_back", tx_rdy_o, 1'b1);
    watch_frame(8'hA5, 16, w);
    check("a5_wait", w, 0);
    @(negedge clk_i);
    check("done_one_cycle", tx_done_tick_o, 1'b0);
    check("idle_tx", tx_o, 1'b1);
    check("idle_busy", busy_o, 1'b0);

    // Back-to-back 0x55 then 0x0F; a request while full must be ignored.
    send(8'h55);
    fork
      watch_frame(8'h55, 16, w);
      begin
        repeat (20) @(negedge clk_i);
        send(8'h0F);
        check("b2b_rdy_low", tx_rdy_o, 1'b0);
        din_bi   = 8'hEE;
        tx_req_i = 1'b1;
        @(negedge clk_i);
        tx_req_i = 1'b0;
        repeat (50) @(negedge clk_i);
        check("b2b_rdy_still_low", tx_rdy_o, 1'b0);
        check("b2b_busy", busy_o, 1'b1);
      end
    join
    watch_frame(8'h0F, 16, w2);
    check("b2b_gap", w2, 0);
    @(negedge clk_i);
    check("b2b_rdy_end", tx_rdy_o, 1'b1);

    // locked_i low: byte waits in the buffer.
    locked_i = 1'b0;
    bitperiod_i = 29'd4;
    send(8'h3C);
    check("lock_rdy", tx_rdy_o, 1'b0);
    check("lock_busy", busy_o, 1'b1);
    repeat (20) @(negedge clk_i);
    check("lock_tx_idle", tx_o, 1'b1);
    check("lock_rdy_hold", tx_rdy_o, 1'b0);
    locked_i = 1'b1;
    watch_frame(8'h3C, 4, w);
    check("lock_launch_lat", w, 1);

    // Zero bit period means one clock per bit.
    @(negedge clk_i);
    bitperiod_i = 29'd0;
    send(8'h96);
    watch_frame(8'h96, 1, w);
    check("bp0_lat", w, 1);

    // Bit period changed mid-frame only affects the next frame.
    @(negedge clk_i);
    bitperiod_i = 29'd16;
    send(8'h6B);
    fork
      watch_frame(8'h6B, 16, w);
      begin
        repeat (40) @(negedge clk_i);
        bitperiod_i = 29'd8;
        send(8'hD2);
      end
    join
    watch_frame(8'hD2, 8, w2);
    check("bpchg_gap", w2, 0);

    // Reset during DATA bit 3 (a zero bit of 0xC3).
    @(negedge clk_i);
    bitperiod_i = 29'd16;
    send(8'hC3);
    w = 0;
    while (tx_o !== 1'b0 && w < 50) begin
      @(negedge clk_i);
      w++;
    end
    repeat (70) @(negedge clk_i);
    check("pre_rst_bit3", tx_o, 1'b0);
    rst_i = 1'b0;
    #1;
    check("mid_rst_tx", tx_o, 1'b1);
    check("mid_rst_rdy", tx_rdy_o, 1'b1);
    check("mid_rst_busy", busy_o, 1'b0);
    repeat (3) @(negedge clk_i);
    check("mid_rst_done", tx_done_tick_o, 1'b0);
    rst_i = 1'b1;
    repeat (200) @(negedge clk_i);
    check("post_rst_tx", tx_o, 1'b1);
    check("post_rst_no_done", tx_done_tick_o, 1'b0);
    send(8'h5A);
    watch_frame(8'h5A, 16, w);
    check("post_rst_lat", w, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
